dct_2d_seq: RTL and testbench
=============================

Name: dct_2d_seq

Overview:
- Sequencer around the shared combinational 1-D DCT row datapath (64-bit in, 96-bit out, 3-bit index select).
- Accepts an 8x8 signed-pixel block one row per beat and runs the row pass into an internal 8x96 transpose buffer.
- Runs the column pass through the same datapath and streams 8 column-result beats out over a valid/ready interface.
- Sits between the block fetcher and the quantiser.

Parameters:
- SCALE_SHIFT, 4, LSB position of the 8-bit field taken from each 12-bit row coefficient for the column pass; legal 0..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  input row valid
- s_ready  out  1  input row ready
- s_data  in  64  row of 8 signed 8-bit pixels; pixel0 in [63:56], pixel7 in [7:0]
- dct_in  out  64  operand to the 1-D DCT datapath, same packing as s_data
- dct_count  out  3  index to the datapath (row index in row pass, column index in column pass)
- dct_out  in  96  datapath result; element j at [95-12j -: 12]; elements 6,7 are zero
- m_valid  out  1  column result valid
- m_ready  in  1  column result ready
- m_data  out  96  column result, dct_out packing
- m_col  out  3  column index of m_data
- m_last  out  1  final beat of block
- busy  out  1  block in progress

Behaviour:
- Reset values: all outputs 0 except s_ready=1 (state ROW, row_idx=0). The transpose buffer is not reset; it is always fully written before it is read.
- States:
  - ROW: s_ready=1. On a handshake, register s_data into the row register, latch row_idx into wr_idx, set pending, then increment row_idx. The handshake that accepts row 7 moves to WB.
  - WB: s_ready=0; one cycle to flush the last pending write, then go to COL with col_idx=0.
  - COL: s_ready=0.
    - dct_in is the gathered column col_idx: byte r = field of tbuf[r] element col_idx.
    - Field = bits [SCALE_SHIFT+7:SCALE_SHIFT] of the 12-bit element. When SCALE_SHIFT<4, saturate to signed 8-bit (+127/-128).
    - dct_count = col_idx.
    - Issue when !m_valid || m_ready: capture dct_out into m_data, set m_col=col_idx and m_valid=1, set m_last=(col_idx==last column), then increment col_idx.
    - Issuing the last column moves to DRAIN.
  - DRAIN: hold until the m_last beat handshakes, then go to ROW with row_idx=0.
- Pending write: when pending=1, tbuf[wr_idx] <= dct_out on the next edge. Meanwhile dct_in = row register and dct_count = wr_idx. Rows can be accepted every cycle, fully pipelined.
- When pending=0 in ROW, dct_in and dct_count hold their last values.
- Latency:
  - First m_valid rises 2 edges after the row-7 handshake edge.
  - With m_ready held at 1, beats arrive on consecutive cycles.
  - Next block's s_ready rises 1 cycle after the m_last handshake.
- Backpressure: while m_valid && !m_ready, m_data, m_col, m_last, col_idx and dct_count stay stable.
- s_valid is ignored outside ROW.
- busy = (state!=ROW) || (row_idx!=0) || pending.
- Asynchronous reset mid-block: abandon the block immediately and return to reset values. No partial beats follow reset release.

Optional Feature:
- SKIP_ZERO_COL_EN
  - Defined: the column pass covers columns 0..5 only; m_last is asserted on m_col=5; 6 output beats per block.
  - Undefined: columns 0..7 are processed; columns 6,7 feed all-zero operands and emit all-zero m_data; m_last is on m_col=7; 8 beats per block.

Test Plan:
- All-zero block, m_ready=1 → 8 beats (6 with SKIP_ZERO_COL_EN), m_data=0, m_col 0..7 in order, m_last on the final beat only, first m_valid 2 edges after the row-7 handshake.
- All pixels = 1, SCALE_SHIFT=4 → the row pass writes element0=91 (row 3: 22). The column-0 pass drives dct_in=64'h0505050105050505 with dct_count=0. Columns 1..7 drive dct_in=0.
- Rows presented with s_valid gaps of 0..3 cycles → identical tbuf contents and identical m_data stream as the back-to-back case.
- m_ready low for 5 cycles on beat m_col=2 → m_data, m_col and dct_count stable throughout; no beat dropped or duplicated; s_ready stays 0.
- rst_n pulsed low in COL after beat 3 → m_valid=0 and s_ready=1 asynchronously. A fresh block after release produces a complete correct 8-beat stream.
- SCALE_SHIFT=2 with element value 0x7F0 → column byte saturates to 0x7F; element 0x810 → 0x80.

Source files
------------

// File: rtl/dct_2d_seq.sv
// 8x8 2-D DCT sequencer: row pass into a transpose buffer, column pass streamed out over valid/ready.
// Define SKIP_ZERO_COL_EN to emit only columns 0..5; columns 6,7 are otherwise emitted as zero beats.
module dct_2d_seq #(
   parameter int SCALE_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [63:0] s_data,
   output logic [63:0] dct_in,
   output logic [2:0]  dct_count,
   input  logic [95:0] dct_out,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [95:0] m_data,
   output logic [2:0]  m_col,
   output logic        m_last,
   output logic        busy
);

`ifdef SKIP_ZERO_COL_EN
   localparam logic [2:0] LAST_COL = 3'd5;
`else
   localparam logic [2:0] LAST_COL = 3'd7;
`endif

   typedef enum logic [1:0] {ST_ROW, ST_WB, ST_COL, ST_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [2:0]  row_idx_q, row_idx_d;
   logic [2:0]  wr_idx_q, wr_idx_d;
   logic        pending_q, pending_d;
   logic [63:0] row_q, row_d;
   logic [2:0]  col_idx_q, col_idx_d;
   logic        col_mode_q, col_mode_d;
   logic        m_valid_q, m_valid_d;
   logic [95:0] m_data_q, m_data_d;
   logic [2:0]  m_col_q, m_col_d;
   logic        m_last_q, m_last_d;

   // Only elements 0..5 carry information, so the buffer keeps their 8-bit column-pass fields.
   logic [7:0]  tbuf_q [8][6];
   logic [7:0]  row_field [6];
   logic [63:0] col_gather;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_field
         logic signed [11:0] elem;
         logic signed [11:0] shifted;
         assign elem    = dct_out[95-12*gi -: 12];
         assign shifted = elem >>> SCALE_SHIFT;
         assign row_field[gi] = (shifted > 12'sd127)  ? 8'h7f :
                                (shifted < -12'sd128) ? 8'h80 : shifted[7:0];
      end
      for (gi = 0; gi < 8; gi++) begin : g_gather
         assign col_gather[63-8*gi -: 8] = (col_idx_q < 3'd6) ? tbuf_q[gi][col_idx_q] : 8'h00;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (pending_q) begin
         for (int e = 0; e < 6; e++) begin
            tbuf_q[wr_idx_q][e] <= row_field[e];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      row_idx_d  = row_idx_q;
      wr_idx_d   = wr_idx_q;
      pending_d  = 1'b0;
      row_d      = row_q;
      col_idx_d  = col_idx_q;
      col_mode_d = col_mode_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_col_d    = m_col_q;
      m_last_d   = m_last_q;
      case (state_q)
         ST_ROW: begin
            if (s_valid) begin
               row_d      = s_data;
               wr_idx_d   = row_idx_q;
               pending_d  = 1'b1;
               row_idx_d  = row_idx_q + 3'd1;
               col_mode_d = 1'b0;
               if (row_idx_q == 3'd7) state_d = ST_WB;
            end
         end
         ST_WB: begin
            col_idx_d  = 3'd0;
            col_mode_d = 1'b1;
            state_d    = ST_COL;
         end
         ST_COL: begin
            if (!m_valid_q || m_ready) begin
               m_valid_d = 1'b1;
               m_data_d  = (col_idx_q < 3'd6) ? dct_out : 96'd0;
               m_col_d   = col_idx_q;
               m_last_d  = (col_idx_q == LAST_COL);
               col_idx_d = col_idx_q + 3'd1;
               if (col_idx_q == LAST_COL) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               row_idx_d = 3'd0;
               state_d   = ST_ROW;
            end
         end
         default: state_d = ST_ROW;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ROW;
         row_idx_q  <= 3'd0;
         wr_idx_q   <= 3'd0;
         pending_q  <= 1'b0;
         row_q      <= 64'd0;
         col_idx_q  <= 3'd0;
         col_mode_q <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= 96'd0;
         m_col_q    <= 3'd0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_idx_q  <= row_idx_d;
         wr_idx_q   <= wr_idx_d;
         pending_q  <= pending_d;
         row_q      <= row_d;
         col_idx_q  <= col_idx_d;
         col_mode_q <= col_mode_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_col_q    <= m_col_d;
         m_last_q   <= m_last_d;
      end
   end

   // The operand mux keeps showing the column view after a block until the next row is accepted.
   assign dct_in    = col_mode_q ? col_gather : row_q;
   assign dct_count = col_mode_q ? col_idx_q : wr_idx_q;
   assign s_ready   = (state_q == ST_ROW);
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_col     = m_col_q;
   assign m_last    = m_last_q;
   assign busy      = (state_q != ST_ROW) || (row_idx_q != 3'd0) || pending_q;

endmodule

// File: tb/tb_dct_2d_seq.sv
// Bench for dct_2d_seq: integer 1-D DCT stand-in datapath, reference 2-D model and beat scoreboard.
// Two instances run in lockstep: SCALE_SHIFT=4 (scoreboarded) and SCALE_SHIFT=2 (saturation).
module tb_dct_2d_seq;

`ifdef SKIP_ZERO_COL_EN
   localparam int NBEATS = 6;
`else
   localparam int NBEATS = 8;
`endif
   localparam int SS_MAIN = 4;
   localparam int C [6][8] = '{
      '{ 91,  91,  91,  91,  91,  91,  91,  91},
      '{126, 106,  71,  25, -25, -71,-106,-126},
      '{118,  49, -49,-118,-118, -49,  49, 118},
      '{106, -25,-126, -71,  71, 126,  25,-106},
      '{ 91, -91, -91,  91,  91, -91, -91,  91},
      '{ 71,-126,  25, 106,-106, -25, 126, -71}};

   typedef struct packed {
      logic [2:0]  col;
      logic [95:0] data;
      logic        last;
   } beat_t;

   logic        clk, rst_n, s_valid, m_ready;
   logic [63:0] s_data;
   logic        s_ready, m_valid, m_last, busy;
   logic [63:0] dct_in;
   logic [2:0]  dct_count, m_col;
   logic [95:0] dct_out, m_data;
   logic        s_ready_b, m_valid_b, m_last_b, busy_b;
   logic [63:0] dct_in_b;
   logic [2:0]  dct_count_b, m_col_b;
   logic [95:0] dct_out_b, m_data_b;

   int    checks = 0;
   int    errors = 0;
   int    beats = 0;
   int    dp_mode = 0;
   beat_t exp_q[$];
   beat_t mon_b;
   logic [63:0] blk [8];
   logic [63:0] exp_colin [8];

   // Stand-in datapath; index 3 is scaled down further so that position dependence is exercised.
   function automatic logic [95:0] dp_model(input logic [63:0] x, input logic [2:0] cnt, input int mode);
      logic [95:0] r;
      int acc;
      r = '0;
      if (mode == 1) return {12'h7f0, 12'h810, 72'h0};
      for (int j = 0; j < 6; j++) begin
         acc = 0;
         for (int i = 0; i < 8; i++) acc += int'($signed(x[63-8*i -: 8])) * C[j][i];
         acc = acc >>> ((cnt == 3'd3) ? 5 : 3);
         r[95-12*j -: 12] = acc[11:0];
      end
      return r;
   endfunction

   function automatic logic [7:0] fld(input logic [11:0] e, input int sh);
      int v;
      v = int'($signed(e));
      v = v >>> sh;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   assign dct_out   = dp_model(dct_in, dct_count, dp_mode);
   assign dct_out_b = dp_model(dct_in_b, dct_count_b, dp_mode);

   dct_2d_seq #(.SCALE_SHIFT(SS_MAIN)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dct_in(dct_in), .dct_count(dct_count), .dct_out(dct_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col),
      .m_last(m_last), .busy(busy));

   dct_2d_seq #(.SCALE_SHIFT(2)) dut_s2 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
      .dct_in(dct_in_b), .dct_count(dct_count_b), .dct_out(dct_out_b),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_col(m_col_b),
      .m_last(m_last_b), .busy(busy_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard: a beat transfers on the next rising edge when valid and ready are both high here.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         beats++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got col=%0d data=%h, expected no beat", m_col, m_data);
         end else begin
            mon_b = exp_q.pop_front();
            if ({m_col, m_data, m_last} !== {mon_b.col, mon_b.data, mon_b.last}) begin
               errors++;
               $display("FAIL beat: got col=%0d data=%h last=%0b, expected col=%0d data=%h last=%0b",
                        m_col, m_data, m_last, mon_b.col, mon_b.data, mon_b.last);
            end
         end
      end
   end

   task automatic compute_expected();
      logic [95:0] rr [8];
      logic [63:0] colin;
      beat_t b;
      for (int r = 0; r < 8; r++) rr[r] = dp_model(blk[r], 3'(r), dp_mode);
      for (int c = 0; c < 8; c++) begin
         colin = '0;
         if (c < 6) for (int r = 0; r < 8; r++) colin[63-8*r -: 8] = fld(rr[r][95-12*c -: 12], SS_MAIN);
         exp_colin[c] = colin;
      end
      for (int c = 0; c < NBEATS; c++) begin
         b.col  = 3'(c);
         b.data = (c < 6) ? dp_model(exp_colin[c], 3'(c), dp_mode) : 96'd0;
         b.last = (c == NBEATS - 1);
         exp_q.push_back(b);
      end
   endtask

   // Returns 1 time unit after the edge that accepts row 7.
   task automatic drive_block(input bit gaps);
      compute_expected();
      @(posedge clk); #1;
      for (int r = 0; r < 8; r++) begin
         s_valid = 1'b0;
         repeat (gaps ? r % 4 : 0) begin @(posedge clk); #1; end
         s_valid = 1'b1;
         s_data  = blk[r];
         checks++;
         if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL row_ready: row %0d got s_ready=%0b, expected 1", r, s_ready);
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input int beats0);
      for (int k = 0; k < 100 && (busy || m_valid); k++) @(negedge clk);
      checks++;
      if (busy || m_valid) begin
         errors++;
         $display("FAIL drain_timeout: got busy=%0b m_valid=%0b after 100 cycles, expected idle", busy, m_valid);
      end
      checks++;
      if (exp_q.size() != 0 || beats - beats0 != NBEATS) begin
         errors++;
         $display("FAIL beat_count: got %0d beats with %0d still queued, expected %0d beats", beats - beats0, exp_q.size(), NBEATS);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_ready, m_valid, m_last, busy, m_col, dct_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset_ctrl: got s_ready=%0b m_valid=%0b m_last=%0b busy=%0b m_col=%0d dct_count=%0d, expected 1 0 0 0 0 0",
                  s_ready, m_valid, m_last, busy, m_col, dct_count);
      end
      checks++;
      if (m_data !== 96'd0 || dct_in !== 64'd0) begin
         errors++;
         $display("FAIL reset_data: got m_data=%h dct_in=%h, expected 0", m_data, dct_in);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got s_ready=%0b busy=%0b, expected 1 0", s_ready, busy);
      end
   endtask

   task automatic test_all_zero();
      int beats0;
      for (int r = 0; r < 8; r++) blk[r] = 64'd0;
      beats0 = beats;
      drive_block(1'b0);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_wb: got m_valid=%0b busy=%0b s_ready=%0b, expected 0 1 0", m_valid, busy, s_ready);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || dct_count !== 3'd0) begin
         errors++;
         $display("FAIL zero_col0: got m_valid=%0b dct_count=%0d, expected 0 0", m_valid, dct_count);
      end
      for (int k = 0; k < NBEATS; k++) begin
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b1 || m_col !== 3'(k) || m_last !== (k == NBEATS - 1)) begin
            errors++;
            $display("FAIL zero_stream: beat %0d got m_valid=%0b m_col=%0d m_last=%0b, expected 1 %0d %0b",
                     k, m_valid, m_col, m_last, k, (k == NBEATS - 1));
         end
      end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_next_ready: got s_ready=%0b m_valid=%0b busy=%0b, expected 1 0 0", s_ready, m_valid, busy);
      end
      wait_idle(beats0);
   endtask

   task automatic test_all_ones();
      int beats0;
      for (int r = 0; r < 8; r++) blk[r] = 64'h0101010101010101;
      beats0 = beats;
      drive_block(1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dct_in !== 64'h0505050105050505 || dct_count !== 3'd0) begin
         errors++;
         $display("FAIL ones_col0: got dct_in=%h dct_count=%0d, expected 0505050105050505 0", dct_in, dct_count);
      end
      for (int k = 1; k < NBEATS; k++) begin
         @(negedge clk);
         checks++;
         if (dct_in !== 64'd0 || dct_count !== 3'(k)) begin
            errors++;
            $display("FAIL ones_colk: got dct_in=%h dct_count=%0d, expected 0 %0d", dct_in, dct_count, k);
         end
      end
      wait_idle(beats0);
   endtask

   task automatic test_gaps();
      int beats0;
      for (int r = 0; r < 8; r++) blk[r] = {$urandom, $urandom};
      for (int pass = 0; pass < 2; pass++) begin
         beats0 = beats;
         drive_block(pass == 1);
         @(negedge clk);
         for (int k = 0; k < NBEATS; k++) begin
            @(negedge clk);
            checks++;
            if (dct_in !== exp_colin[k] || dct_count !== 3'(k)) begin
               errors++;
               $display("FAIL gaps_col: pass %0d got dct_in=%h dct_count=%0d, expected %h %0d",
                        pass, dct_in, dct_count, exp_colin[k], k);
            end
         end
         wait_idle(beats0);
      end
   endtask

   task automatic test_backpressure();
      int beats0;
      bit found;
      beat_t b2;
      for (int r = 0; r < 8; r++) blk[r] = {$urandom, $urandom};
      beats0 = beats;
      drive_block(1'b0);
      b2 = exp_q[2];
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk); #1;
         found = m_valid && (m_col == 3'd2);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL bp_find: got no beat with m_col=2 within 20 cycles, expected one");
      end
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({m_valid, m_col, m_data, dct_count, s_ready} !== {1'b1, 3'd2, b2.data, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got m_valid=%0b m_col=%0d data=%h dct_count=%0d s_ready=%0b, expected 1 2 %h 3 0",
                     k, m_valid, m_col, m_data, dct_count, s_ready, b2.data);
         end
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_idle(beats0);
   endtask

   task automatic test_reset_mid();
      int beats0;
      bit found;
      bit quiet;
      for (int r = 0; r < 8; r++) blk[r] = {$urandom, $urandom};
      drive_block(1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk); #1;
         found = m_valid && (m_col == 3'd3);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (!found || m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got found=%0b m_valid=%0b s_ready=%0b busy=%0b, expected 1 0 1 0", found, m_valid, s_ready, busy);
      end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (m_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL rst_quiet: got m_valid=1 after reset release, expected 0");
      end
      for (int r = 0; r < 8; r++) blk[r] = {$urandom, $urandom};
      beats0 = beats;
      drive_block(1'b0);
      wait_idle(beats0);
   endtask

   task automatic test_saturation();
      int beats0;
      logic [95:0] last_b;
      dp_mode = 1;
      for (int r = 0; r < 8; r++) blk[r] = {$urandom, $urandom};
      beats0 = beats;
      drive_block(1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dct_in_b !== 64'h7f7f7f7f7f7f7f7f || dct_in !== 64'h7f7f7f7f7f7f7f7f) begin
         errors++;
         $display("FAIL sat_pos: got shift2=%h shift4=%h, expected 7f7f7f7f7f7f7f7f both", dct_in_b, dct_in);
      end
      checks++;
      if ({dct_count_b, s_ready_b, busy_b, m_valid_b} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sat_ctrl: got dct_count=%0d s_ready=%0b busy=%0b m_valid=%0b, expected 0 0 1 0",
                  dct_count_b, s_ready_b, busy_b, m_valid_b);
      end
      @(negedge clk);
      checks++;
      if (dct_in_b !== 64'h8080808080808080 || dct_in !== 64'h8181818181818181) begin
         errors++;
         $display("FAIL sat_neg: got shift2=%h shift4=%h, expected 8080808080808080 8181818181818181", dct_in_b, dct_in);
      end
      wait_idle(beats0);
      last_b = (NBEATS == 6) ? {12'h7f0, 12'h810, 72'h0} : 96'd0;
      checks++;
      if (m_data_b !== last_b || m_col_b !== 3'(NBEATS - 1) || m_last_b !== 1'b0) begin
         errors++;
         $display("FAIL sat_last: got data=%h col=%0d last=%0b, expected %h %0d 0", m_data_b, m_col_b, m_last_b, last_b, NBEATS - 1);
      end
      dp_mode = 0;
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 64'd0;
      m_ready = 1'b1;
      test_reset();
      test_all_zero();
      test_all_ones();
      test_gaps();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
